alu_div_seq: RTL and testbench
==============================

Name: alu_div_seq

Overview:
- Multi-cycle divide sequencer. It performs 32-bit unsigned or signed restoring division by driving the shared combinational ALU through a port interface; it has no internal divide arithmetic.
- Each iteration issues one ALU SLTU compare, then one ALU SUB.
- Sits beside the single-cycle ALU. The core's control muxes the ALU operand/op inputs to this block while busy_o is high.

Parameters:
- DATA_W, 32: operand width. Must equal the ALU width; only 32 is supported.
- SUB_OP, 6'b100010: ALU opcode for subtract.
- SLTU_OP, 6'b101011: ALU opcode for unsigned set-less-than. ALU result bit 0 = (a <u b).
- IDLE_OP, 6'b100000: ALU opcode (ADD) driven when idle.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  synchronous active-high reset.
- start_i  input  1  request a divide; sampled only in IDLE.
- signed_i  input  1  1 = signed divide, 0 = unsigned; captured with start_i.
- dividend_i  input  32  dividend; captured with start_i.
- divisor_i  input  32  divisor; captured with start_i.
- alu_a_o  output  32  ALU operand A.
- alu_b_o  output  32  ALU operand B.
- alu_op_o  output  6  ALU opcode.
- alu_res_i  input  32  ALU result, same cycle (ALU is combinational).
- busy_o  output  1  divide in progress.
- done_o  output  1  one-cycle pulse: results valid.
- dbz_o  output  1  divide-by-zero flag for last op; held until next accepted start.
- quotient_o  output  32  quotient; held until next accepted start.
- remainder_o  output  32  remainder; held until next accepted start.

Behaviour:
- Reset (rst_i high at an edge):
  - FSM goes to IDLE.
  - busy_o, done_o, dbz_o, quotient_o and remainder_o all go to 0.
  - Internal registers are cleared.
  - Reset overrides any in-flight divide; no done_o is produced for the aborted op.
- FSM states: IDLE, CMP, SUB, FIN.
- IDLE:
  - alu_a_o = 0, alu_b_o = 0, alu_op_o = IDLE_OP.
  - On edge E0 with start_i = 1: latch the magnitudes |dividend| and |divisor| (two's-complement negate when signed_i and bit 31 set). Record sign_q = sa^sb and sign_r = sa (signed only). Clear the remainder accumulator R. Set iter = 31. Clear dbz_o and done_o.
  - If divisor_i == 0: go to FIN with the dbz path. Otherwise go to CMP.
- busy_o:
  - 1 in CMP, SUB and FIN; 0 in IDLE.
  - start_i while busy_o = 1 is ignored; there is no queueing.
- CMP:
  - Form R' = {R[30:0], dividend_mag[iter]}.
  - Drive alu_a_o = R', alu_b_o = divisor_mag, alu_op_o = SLTU_OP.
  - Latch lt = alu_res_i[0] and R' → R.
  - Go to SUB.
- SUB:
  - Drive alu_a_o = R, alu_b_o = divisor_mag, alu_op_o = SUB_OP.
  - If !lt: R ← alu_res_i and quotient bit [iter] = 1. Otherwise R is unchanged and the bit = 0.
  - If iter == 0: go to FIN. Else iter ← iter−1 and go to CMP.
  - The SUB cycle is always spent, so latency is fixed.
- FIN:
  - ALU is driven as in IDLE.
  - Normal path: quotient_o ← sign_q ? −Q : Q; remainder_o ← sign_r ? −R : R.
  - dbz path: quotient_o ← 32'hFFFF_FFFF, remainder_o ← original dividend_i value (unmodified), dbz_o ← 1.
  - On the next edge, done_o = 1 for exactly one cycle and the FSM returns to IDLE.
- Latency, normal divide:
  - Start accepted at E0 → CMP/SUB pairs occupy E0..E64 → FIN, registered at E65.
  - done_o and results are visible after E65 and deasserted after E66.
  - A new start_i is accepted at earliest E66 (same edge done_o drops).
- Latency, divide-by-zero: FIN at E1, done_o visible after E1.
- Arithmetic:
  - All internal arithmetic is mod 2^32. Negation is ~x+1 done locally, not via the ALU.
  - Signed 0x80000000 / −1 gives q = 0x80000000, r = 0, dbz_o = 0 (wraps, no trap).
  - The remainder carries the sign of the dividend; the quotient truncates toward zero.

Test Plan:
- Unsigned 100 / 7 → q = 14, r = 2, dbz_o = 0. done_o asserts exactly 65 edges after start is accepted; busy_o is high throughout.
- Signed −100 / 7 → q = 0xFFFFFFF2, r = 0xFFFFFFFE. Also signed 100 / −7 → q = 0xFFFFFFF2, r = 2.
- Divisor 0, dividend 0x12345678 (both modes) → done_o one edge after start, q = 0xFFFFFFFF, r = 0x12345678, dbz_o = 1. The next normal divide clears dbz_o.
- Boundaries:
  - Unsigned 0xFFFFFFFF / 1 → q = 0xFFFFFFFF, r = 0.
  - Signed 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0.
  - Unsigned 5 / 9 → q = 0, r = 5.
- Pulse start_i with different operands at cycles 10 and 40 after the first start → both ignored, first result unchanged. Check alu_op_o alternates SLTU_OP/SUB_OP while busy and is IDLE_OP when idle.
- Assert rst_i for one cycle at iteration 20 → busy_o = 0 and all outputs 0 next cycle, no done_o. A fresh 100 / 7 then completes correctly.

Source files
------------

// File: rtl/alu_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_seq
// Description : Multi-cycle 32-bit signed/unsigned restoring divide sequencer.
//               All compare/subtract work runs on the shared combinational
//               ALU through the alu_* port group. Only magnitude negation
//               and shifting are done locally.
//
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      divide request, sampled only while idle
//   signed_i     1 = signed divide, captured with start_i
//   dividend_i   dividend, captured with start_i
//   divisor_i    divisor, captured with start_i
//   alu_a_o      ALU operand A
//   alu_b_o      ALU operand B
//   alu_op_o     ALU opcode
//   alu_res_i    ALU result (same cycle)
//   busy_o       divide in progress
//   done_o       one-cycle pulse, results valid
//   dbz_o        divide-by-zero flag for the last operation
//   quotient_o   quotient, held until the next accepted start
//   remainder_o  remainder, held until the next accepted start
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div_seq #(
    parameter int         DATA_W  = 32,
    parameter logic [5:0] SUB_OP  = 6'b100010,
    parameter logic [5:0] SLTU_OP = 6'b101011,
    parameter logic [5:0] IDLE_OP = 6'b100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [5:0]        alu_op_o,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              dbz_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int                IW          = $clog2(DATA_W);
    localparam logic [IW-1:0]     c_iter_init = IW'(DATA_W - 1);
    localparam logic [DATA_W-1:0] c_one       = DATA_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_SUB  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            r_state_q,    w_state_d;
    logic [DATA_W-1:0] r_dvd_q,      w_dvd_d;      // |dividend|, or raw dividend on dbz
    logic [DATA_W-1:0] r_dvs_q,      w_dvs_d;      // |divisor|
    logic [DATA_W-1:0] r_rem_q,      w_rem_d;      // partial remainder R
    logic [DATA_W-1:0] r_acc_q,      w_acc_d;      // unsigned quotient being built
    logic [IW-1:0]     r_iter_q,     w_iter_d;
    logic              r_lt_q,       w_lt_d;
    logic              r_neg_quo_q,  w_neg_quo_d;
    logic              r_neg_rem_q,  w_neg_rem_d;
    logic              r_dbz_pend_q, w_dbz_pend_d;
    logic              r_done_q,     w_done_d;
    logic              r_dbz_q,      w_dbz_d;
    logic [DATA_W-1:0] r_quot_q,     w_quot_d;
    logic [DATA_W-1:0] r_remo_q,     w_remo_d;

    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic              w_dvs_zero;
    logic [DATA_W-1:0] w_rem_shift;

    assign w_dvd_neg   = signed_i & dividend_i[DATA_W-1];
    assign w_dvs_neg   = signed_i & divisor_i[DATA_W-1];
    assign w_dvs_zero  = (divisor_i == '0);
    assign w_rem_shift = {r_rem_q[DATA_W-2:0], r_dvd_q[r_iter_q]};

    always_comb begin
        w_state_d    = r_state_q;
        w_dvd_d      = r_dvd_q;
        w_dvs_d      = r_dvs_q;
        w_rem_d      = r_rem_q;
        w_acc_d      = r_acc_q;
        w_iter_d     = r_iter_q;
        w_lt_d       = r_lt_q;
        w_neg_quo_d  = r_neg_quo_q;
        w_neg_rem_d  = r_neg_rem_q;
        w_dbz_pend_d = r_dbz_pend_q;
        w_done_d     = 1'b0;
        w_dbz_d      = r_dbz_q;
        w_quot_d     = r_quot_q;
        w_remo_d     = r_remo_q;
        alu_a_o      = '0;
        alu_b_o      = '0;
        alu_op_o     = IDLE_OP;

        case (r_state_q)
            S_IDLE: begin
                if (start_i) begin
                    // On divide-by-zero the raw dividend is kept so it can
                    // be returned unmodified as the remainder.
                    if (w_dvs_zero)
                        w_dvd_d = dividend_i;
                    else
                        w_dvd_d = w_dvd_neg ? (~dividend_i + c_one) : dividend_i;
                    w_dvs_d      = w_dvs_neg ? (~divisor_i + c_one) : divisor_i;
                    w_neg_quo_d  = w_dvd_neg ^ w_dvs_neg;
                    w_neg_rem_d  = w_dvd_neg;
                    w_rem_d      = '0;
                    w_acc_d      = '0;
                    w_iter_d     = c_iter_init;
                    w_lt_d       = 1'b0;
                    w_dbz_pend_d = w_dvs_zero;
                    w_dbz_d      = 1'b0;
                    w_state_d    = w_dvs_zero ? S_FIN : S_CMP;
                end
            end

            S_CMP: begin
                alu_a_o   = w_rem_shift;
                alu_b_o   = r_dvs_q;
                alu_op_o  = SLTU_OP;
                w_lt_d    = alu_res_i[0];
                w_rem_d   = w_rem_shift;
                w_state_d = S_SUB;
            end

            S_SUB: begin
                // The ALU is driven with the subtract every iteration so the
                // latency does not depend on the data.
                alu_a_o  = r_rem_q;
                alu_b_o  = r_dvs_q;
                alu_op_o = SUB_OP;
                if (!r_lt_q) begin
                    w_rem_d           = alu_res_i;
                    w_acc_d[r_iter_q] = 1'b1;
                end
                if (r_iter_q == '0) begin
                    w_state_d = S_FIN;
                end else begin
                    w_iter_d  = r_iter_q - 1'b1;
                    w_state_d = S_CMP;
                end
            end

            default: begin // S_FIN
                if (r_dbz_pend_q) begin
                    w_quot_d = '1;
                    w_remo_d = r_dvd_q;
                    w_dbz_d  = 1'b1;
                end else begin
                    w_quot_d = r_neg_quo_q ? (~r_acc_q + c_one) : r_acc_q;
                    w_remo_d = r_neg_rem_q ? (~r_rem_q + c_one) : r_rem_q;
                end
                w_done_d  = 1'b1;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q    <= S_IDLE;
            r_dvd_q      <= '0;
            r_dvs_q      <= '0;
            r_rem_q      <= '0;
            r_acc_q      <= '0;
            r_iter_q     <= '0;
            r_lt_q       <= 1'b0;
            r_neg_quo_q  <= 1'b0;
            r_neg_rem_q  <= 1'b0;
            r_dbz_pend_q <= 1'b0;
            r_done_q     <= 1'b0;
            r_dbz_q      <= 1'b0;
            r_quot_q     <= '0;
            r_remo_q     <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_dvd_q      <= w_dvd_d;
            r_dvs_q      <= w_dvs_d;
            r_rem_q      <= w_rem_d;
            r_acc_q      <= w_acc_d;
            r_iter_q     <= w_iter_d;
            r_lt_q       <= w_lt_d;
            r_neg_quo_q  <= w_neg_quo_d;
            r_neg_rem_q  <= w_neg_rem_d;
            r_dbz_pend_q <= w_dbz_pend_d;
            r_done_q     <= w_done_d;
            r_dbz_q      <= w_dbz_d;
            r_quot_q     <= w_quot_d;
            r_remo_q     <= w_remo_d;
        end
    end

    assign busy_o      = (r_state_q != S_IDLE);
    assign done_o      = r_done_q;
    assign dbz_o       = r_dbz_q;
    assign quotient_o  = r_quot_q;
    assign remainder_o = r_remo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_div_seq
// Description : Directed self-checking bench for alu_div_seq with a small
//               behavioural model of the shared combinational ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_div_seq;

    localparam logic [5:0] c_sub_op  = 6'b100010;
    localparam logic [5:0] c_sltu_op = 6'b101011;
    localparam logic [5:0] c_idle_op = 6'b100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_op;
    logic [31:0] alu_res;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] quo;
    logic [31:0] rem;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Shared combinational ALU model
    always_comb begin
        alu_res = alu_a + alu_b;
        if (alu_op == c_sltu_op)
            alu_res = {31'd0, (alu_a < alu_b)};
        else if (alu_op == c_sub_op)
            alu_res = alu_a - alu_b;
    end

    alu_div_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .signed_i    (sgn),
        .dividend_i  (dvd),
        .divisor_i   (dvs),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_res_i   (alu_res),
        .busy_o      (busy),
        .done_o      (done),
        .dbz_o       (dbz),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Presents a request for one edge (E0); returns #1 after E0.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        dvd   = a;
        dvs   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dvd   = 32'hDEAD_BEEF;
        dvs   = 32'h0000_0003;
    endtask

    // Follows a running divide to completion, checking busy, opcode sequence,
    // latency, results and the single-cycle done pulse. Optionally fires
    // ignored start pulses at edges 10 and 40 after E0.
    task automatic wait_done(input string tag, input int exp_lat, input logic is_dbz,
                             input logic [31:0] eq, input logic [31:0] er,
                             input logic pulse);
        int         n       = 0;
        int         busy_bd = 0;
        int         op_bd   = 0;
        logic [5:0] exp_op;
        while (done !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) busy_bd++;
            if (is_dbz || n >= 64) exp_op = c_idle_op;
            else                   exp_op = (n % 2 == 0) ? c_sltu_op : c_sub_op;
            if (alu_op !== exp_op) op_bd++;
            if (pulse && (n == 9 || n == 39)) begin
                start = 1'b1;
                sgn   = 1'b0;
                dvd   = 32'd1000;
                dvs   = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_run"}, busy_bd, 0);
        check({tag, "_op_seq"}, op_bd, 0);
        check({tag, "_quot"}, quo, eq);
        check({tag, "_rem"}, rem, er);
        check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, is_dbz});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_op"}, {26'd0, alu_op}, {26'd0, c_idle_op});
    endtask

    initial begin
        int seen_done;
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz",  {31'd0, dbz},  32'd0);
        check("rst_quot", quo, 32'd0);
        check("rst_rem",  rem, 32'd0);
        check("rst_op",   {26'd0, alu_op}, {26'd0, c_idle_op});
        check("rst_a",    alu_a, 32'd0);

        // Unsigned 100/7 with ignored start pulses mid-run
        start_op(1'b0, 32'd100, 32'd7);
        wait_done("u100_7", 65, 1'b0, 32'd14, 32'd2, 1'b1);

        // Signed sign combinations
        start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done("s_m100_7", 65, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        start_op(1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done("s_100_m7", 65, 1'b0, 32'hFFFF_FFF2, 32'd2, 1'b0);

        // Divide by zero in both modes
        start_op(1'b0, 32'h1234_5678, 32'd0);
        wait_done("u_dbz", 1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        start_op(1'b1, 32'h1234_5678, 32'd0);
        wait_done("s_dbz", 1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);

        // Boundaries (first one also clears dbz)
        start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("u_max_1", 65, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("s_min_m1", 65, 1'b0, 32'h8000_0000, 32'd0, 1'b0);
        start_op(1'b0, 32'd5, 32'd9);
        wait_done("u5_9", 65, 1'b0, 32'd0, 32'd5, 1'b0);

        // Leave a dbz result standing, then abort a divide with reset
        start_op(1'b0, 32'h1234_5678, 32'd0);
        wait_done("pre_rst_dbz", 1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        start_op(1'b0, 32'd100, 32'd7);
        repeat (39) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dbz",  {31'd0, dbz},  32'd0);
        check("abort_quot", quo, 32'd0);
        check("abort_rem",  rem, 32'd0);
        check("abort_op",   {26'd0, alu_op}, {26'd0, c_idle_op});
        seen_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        check("abort_no_done", seen_done, 0);

        start_op(1'b0, 32'd100, 32'd7);
        wait_done("post_rst", 65, 1'b0, 32'd14, 32'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
